instruction_fetch: RTL and testbench

- Fetch stage sitting directly downstream of the 64x16 instruction memory.
- Owns the program counter and drives the memory read address and read enable.
- Captures the combinationally-read instruction word into an output register.
- Hands it to the decoder over a valid/ready handshake; supports start, branch redirect (with flush), halt detection and backpressure.

---
 rtl/instruction_fetch.sv | 155 +++++++++++++++
 tb/tb_instruction_fetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a combinational instruction memory and hands
// registered words to the decoder over valid/ready. Optional perf counters: IFETCH_PERF_COUNT_EN.
module instruction_fetch #(
  parameter int unsigned             ADDR_W    = 6,
  parameter int unsigned             INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]       RESET_PC  = {ADDR_W{1'b0}},
  parameter logic [INSTR_W-1:0]      HALT_WORD = {INSTR_W{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  mem_read_address,
  output logic               mem_read_enable,
  input  logic [INSTR_W-1:0] mem_instruction_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
`ifdef IFETCH_PERF_COUNT_EN
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_count,
`endif
  output logic               halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               halted_q;
  logic               en_q;
  logic               transfer_s;
  logic               load_s;

  assign transfer_s = valid_q && instr_ready;
  assign load_s     = (state_q == S_FETCH) && !branch_valid && (!valid_q || instr_ready);

  // Next-state: branch flush beats halt detection beats capture beats stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q && !transfer_s;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (branch_valid) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else if (load_s && (mem_instruction_in == HALT_WORD)) begin
          state_d = S_HALTED;
        end else if (load_s) begin
          instr_d = mem_instruction_in;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          pc_d    = pc_q;
        end
      end
      S_HALTED: begin
        // A pending word is kept across restart and drains via the default above.
        if (start) begin
          pc_d    = start_pc;
          state_d = S_FETCH;
        end else begin
          state_d = S_HALTED;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= {INSTR_W{1'b0}};
      ipc_q    <= {ADDR_W{1'b0}};
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= (state_d == S_HALTED);
      en_q     <= (state_d == S_FETCH);
    end
  end

  assign mem_read_address = pc_q;
  assign mem_read_enable  = en_q;
  assign instr_out        = instr_q;
  assign instr_pc         = ipc_q;
  assign instr_valid      = valid_q;
  assign halted           = halted_q;

`ifdef IFETCH_PERF_COUNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;
  logic        count_xfer_s;
  logic        count_stall_s;

  // A word flushed by a branch in the same cycle is not a delivery.
  assign count_xfer_s  = transfer_s && !((state_q == S_FETCH) && branch_valid);
  assign count_stall_s = (state_q == S_FETCH) && valid_q && !instr_ready;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      if (count_xfer_s && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'h0001;
      end else begin
        fetch_cnt_q <= fetch_cnt_q;
      end
      if (count_stall_s && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'h0001;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a behavioural combinational memory.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  start_pc;
  logic        branch_valid;
  logic [5:0]  branch_target;
  logic [5:0]  mem_read_address;
  logic        mem_read_enable;
  logic [15:0] mem_instruction_in;
  logic [15:0] instr_out;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
`ifdef IFETCH_PERF_COUNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  logic [15:0] mem [64];
  int          n_checks;
  int          n_pass;

  assign mem_instruction_in = mem[mem_read_address];

  instruction_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .start_pc          (start_pc),
    .branch_valid      (branch_valid),
    .branch_target     (branch_target),
    .mem_read_address  (mem_read_address),
    .mem_read_enable   (mem_read_enable),
    .mem_instruction_in(mem_instruction_in),
    .instr_out         (instr_out),
    .instr_pc          (instr_pc),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
`ifdef IFETCH_PERF_COUNT_EN
    .fetch_count       (fetch_count),
    .stall_count       (stall_count),
`endif
    .halted            (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] w, input logic [5:0] p,
                           input logic [5:0] addr);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check_eq({tag, "_out"},   32'(instr_out),   32'(w));
    check_eq({tag, "_pc"},    32'(instr_pc),    32'(p));
    check_eq({tag, "_addr"},  32'(mem_read_address), 32'(addr));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h1000;
    mem[1]  = 16'h1001;
    mem[2]  = 16'h1002;
    mem[3]  = 16'h1003;
    mem[4]  = 16'h1004;
    mem[5]  = 16'h1005;
    mem[10] = 16'hAAAA;
    mem[11] = 16'hBBBB;
    mem[40] = 16'h4040;
    mem[62] = 16'h2222;
    mem[63] = 16'h3333;
    rst = 1'b1; start = 1'b0; start_pc = 6'd0;
    branch_valid = 1'b0; branch_target = 6'd0; instr_ready = 1'b1;

    // Reset and idle, with a branch pulse that must be ignored
    step(); step();
    rst = 1'b0;
    step();
    branch_valid = 1'b1; branch_target = 6'd40;
    step();
    branch_valid = 1'b0;
    step();
    check_eq("idle_en",     32'(mem_read_enable), 32'd0);
    check_eq("idle_valid",  32'(instr_valid),     32'd0);
    check_eq("idle_out",    32'(instr_out),       32'd0);
    check_eq("idle_addr",   32'(mem_read_address), 32'd0);
    check_eq("idle_halted", 32'(halted),          32'd0);

    // Streaming start at 0
    start = 1'b1; start_pc = 6'd0;
    step();
    start = 1'b0;
    check_eq("start1_valid", 32'(instr_valid),     32'd0);
    check_eq("start1_en",    32'(mem_read_enable), 32'd1);
    step();
    check_out("w0", 16'h1000, 6'd0, 6'd1);
    step();
    check_out("w1", 16'h1001, 6'd1, 6'd2);

    // Backpressure on 0x1001
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall", 16'h1001, 6'd1, 6'd2);
    end
    instr_ready = 1'b1;
    step();
    check_out("w2", 16'h1002, 6'd2, 6'd3);
    step();
    check_out("w3", 16'h1003, 6'd3, 6'd4);
    step();
    check_out("w4", 16'h1004, 6'd4, 6'd5);

    // Branch flush while valid, pc=5
    branch_valid = 1'b1; branch_target = 6'd40;
    step();
    branch_valid = 1'b0;
    check_eq("br_valid", 32'(instr_valid),      32'd0);
    check_eq("br_addr",  32'(mem_read_address), 32'd40);
    step();
    check_out("br_tgt", 16'h4040, 6'd40, 6'd41);

    // Wrap and halt
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem[0] = 16'hFFFF;
    start = 1'b1; start_pc = 6'd62;
    step();
    start = 1'b0;
    step();
    check_out("wr62", 16'h2222, 6'd62, 6'd63);
    step();
    check_out("wr63", 16'h3333, 6'd63, 6'd0);
    step();
    check_eq("halt_halted", 32'(halted),           32'd1);
    check_eq("halt_valid",  32'(instr_valid),      32'd0);
    check_eq("halt_addr",   32'(mem_read_address), 32'd0);
    check_eq("halt_en",     32'(mem_read_enable),  32'd0);
    branch_valid = 1'b1; branch_target = 6'd40;
    step();
    branch_valid = 1'b0;
    check_eq("halt2_halted", 32'(halted),           32'd1);
    check_eq("halt2_valid",  32'(instr_valid),      32'd0);
    check_eq("halt2_addr",   32'(mem_read_address), 32'd0);

    // Restart from HALTED at 10
    start = 1'b1; start_pc = 6'd10;
    step();
    start = 1'b0;
    check_eq("rs_halted", 32'(halted),           32'd0);
    check_eq("rs_addr",   32'(mem_read_address), 32'd10);
    step();
    check_out("rs10", 16'hAAAA, 6'd10, 6'd11);

    // Reset while holding a stalled word
    instr_ready = 1'b0;
    step();
    check_out("pre_rst", 16'hAAAA, 6'd10, 6'd11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mrst_valid",  32'(instr_valid),      32'd0);
    check_eq("mrst_out",    32'(instr_out),        32'd0);
    check_eq("mrst_ipc",    32'(instr_pc),         32'd0);
    check_eq("mrst_addr",   32'(mem_read_address), 32'd0);
    check_eq("mrst_en",     32'(mem_read_enable),  32'd0);
    check_eq("mrst_halted", 32'(halted),           32'd0);
`ifdef IFETCH_PERF_COUNT_EN
    check_eq("mrst_fetch_cnt", 32'(fetch_count), 32'd0);
    check_eq("mrst_stall_cnt", 32'(stall_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
